// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter and its
// round-robin winner picker.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2
    } arb_state_t;

    // Read data returned to a requester whose slave response timed out.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hBADC_AB1E;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// winner and wraps, so the most recent winner has the lowest priority.
module rr_arbiter
    import periph_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic               o_any,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]    o_idx
);

    int w_dist;
    int w_best;

    // Each requester's distance from the priority head; the smallest
    // requesting distance wins.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(i_last) - 1;
            if (w_dist < 0) w_dist = w_dist + NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = ID_W'(i);
                o_any  = 1'b1;
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_onehot[i] = o_any && (o_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares one peripheral slave port among NUM_REQ requesters with
// round-robin arbitration, one outstanding transaction and a response timeout.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 2,
    parameter int  ADDR_WIDTH     = 12,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int ID_W           = id_width(NUM_REQ)
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] add_i,
    input  logic [NUM_REQ-1:0]            wen_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            r_valid_o,
    output logic [NUM_REQ-1:0]            r_err_o,
    output logic [31:0]                   r_rdata_o,
    output logic                          m_req_o,
    output logic [ADDR_WIDTH-1:0]         m_add_o,
    output logic                          m_wen_o,
    output logic [31:0]                   m_wdata_o,
    output logic [3:0]                    m_be_o,
    output logic [ID_W-1:0]               m_id_o,
    input  logic                          m_gnt_i,
    input  logic                          m_r_valid_i,
    input  logic [31:0]                   m_r_rdata_i
);

    // Counter value in the last allowed waiting cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t         r_state;
    logic [ID_W-1:0]    r_winner;
    logic [NUM_REQ-1:0] r_win_oh;
    logic [ID_W-1:0]    r_last;
    logic [15:0]        r_cnt;

    logic               w_any;
    logic [NUM_REQ-1:0] w_oh;
    logic [ID_W-1:0]    w_idx;
    logic               w_issue;
    logic               w_wait;
    logic               w_tmo;
    logic               w_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req    (req_i),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_onehot (w_oh),
        .o_idx    (w_idx)
    );

    assign w_issue = (r_state == ST_ISSUE);
    assign w_wait  = (r_state == ST_WAIT_R);
    // A real response in the final cycle beats the timeout.
    assign w_tmo   = w_wait && !m_r_valid_i && (r_cnt == CNT_LAST);
    assign w_done  = w_wait && (m_r_valid_i || w_tmo);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_winner <= '0;
            r_win_oh <= '0;
            r_last   <= ID_W'(NUM_REQ - 1);
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_winner <= w_idx;
                        r_win_oh <= w_oh;
                        r_last   <= w_idx;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (w_done) r_state <= ST_IDLE;
                    else        r_cnt   <= r_cnt + 16'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request fields follow the winner's live inputs while issuing.
    always_comb begin
        m_req_o   = w_issue;
        m_id_o    = '0;
        m_add_o   = '0;
        m_wen_o   = 1'b0;
        m_wdata_o = '0;
        m_be_o    = '0;
        if (w_issue) begin
            m_id_o = r_winner;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_win_oh[i]) begin
                    m_add_o   = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    m_wen_o   = wen_i[i];
                    m_wdata_o = wdata_i[i*32 +: 32];
                    m_be_o    = be_i[i*4 +: 4];
                end
            end
        end
    end

    assign gnt_o     = (w_issue && m_gnt_i) ? r_win_oh : '0;
    assign r_valid_o = w_done ? r_win_oh : '0;
    assign r_err_o   = w_tmo  ? r_win_oh : '0;
    assign r_rdata_o = w_done ? (m_r_valid_i ? m_r_rdata_i : TIMEOUT_RDATA) : '0;

endmodule
